// File: rtl/spi_pkg.sv
// spi_pkg: shared types, constants and chip-select decode for spi_master.
// Optional feature macro: SPI_MASTER_PARITY_EN (adds one even-parity bit to each frame direction).
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TX,
        ST_RX,
        ST_HOLD
    } spi_state_t;

    localparam int unsigned SPI_TX_BITS = 68;
    localparam int unsigned SPI_RX_BITS = 32;
    localparam int unsigned SPI_NUM_SLV = 3;
    localparam int unsigned SPI_CNT_W   = 7;

    localparam int unsigned SPI_SLV_ALU = 0;
    localparam int unsigned SPI_SLV_MUL = 1;
    localparam int unsigned SPI_SLV_BAS = 2;

`ifdef SPI_MASTER_PARITY_EN
    localparam int unsigned SPI_PAR_BITS = 1;
`else
    localparam int unsigned SPI_PAR_BITS = 0;
`endif

    localparam int unsigned SPI_TX_FRAME = SPI_TX_BITS + SPI_PAR_BITS;
    localparam int unsigned SPI_RX_FRAME = SPI_RX_BITS + SPI_PAR_BITS;

    // Command payload, MSB first on the wire
    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
    } spi_req_t;

    // One-hot-low chip select for a slave index; invalid index selects nobody
    function automatic logic [SPI_NUM_SLV-1:0] spi_cs_decode(input logic [1:0] sel);
        logic [SPI_NUM_SLV-1:0] cs;
        cs = '1;
        case (sel)
            2'(SPI_SLV_ALU): cs = 3'b110;
            2'(SPI_SLV_MUL): cs = 3'b101;
            2'(SPI_SLV_BAS): cs = 3'b011;
            default:         cs = '1;
        endcase
        return cs;
    endfunction

endpackage

// File: rtl/spi_if.sv
// spi_if: CPU request/response handshake plus the shared SPI wires.
interface spi_if;
    logic        start;
    logic [1:0]  slave_sel;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [2:0]  cs_n;

    modport master (
        input  start, slave_sel, opcode, operand_a, operand_b, miso,
        output busy, done, result, err, sclk, mosi, cs_n
    );

    modport slave (
        output start, slave_sel, opcode, operand_a, operand_b, miso,
        input  busy, done, result, err, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: SCK divider; toggles sclk every CLK_DIV clocks while enabled and
// flags the clock on which a rising or falling SCK edge is due.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic sck_en_i,
    output logic sclk_o,
    output logic rise_tick_c,
    output logic fall_tick_c
);
    localparam int unsigned DIV_W = 8;

    logic [DIV_W-1:0] cnt_q;
    logic             sclk_q;
    logic             half_c;

    assign half_c      = en_i && (cnt_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick_c = half_c && !sclk_q;
    assign fall_tick_c = half_c && sclk_q;
    assign sclk_o      = sclk_q;

    // Half-period counter; sclk held low when disabled or when toggling is masked
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (half_c) begin
            cnt_q <= '0;
            if (sck_en_i) begin
                sclk_q <= !sclk_q;
            end
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator that ships a command frame to one coprocessor
// slave and shifts its 32-bit result back. Optional macro: SPI_MASTER_PARITY_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    spi_if.master bus
);
    spi_state_t                state_q;
    logic [SPI_CNT_W-1:0]      bit_cnt_q;
    logic [SPI_TX_FRAME-2:0]   tx_sr_q;
    logic [SPI_RX_FRAME-1:0]   rx_sr_q;
    logic                      busy_q;
    logic                      done_q;
    logic [SPI_RX_BITS-1:0]    result_q;
    logic                      mosi_q;
    logic [SPI_NUM_SLV-1:0]    cs_n_q;

    spi_req_t                  req_c;
    logic [SPI_TX_FRAME-1:0]   frame_c;
    logic                      clk_en_c;
    logic                      sck_en_c;
    logic                      rise_tick_c;
    logic                      fall_tick_c;
    logic                      sclk_w;

    // Assemble the outgoing frame from the live request inputs
    always_comb begin
        req_c = '{opcode: bus.opcode, operand_a: bus.operand_a, operand_b: bus.operand_b};
`ifdef SPI_MASTER_PARITY_EN
        frame_c = {req_c, ^req_c};
`else
        frame_c = req_c;
`endif
    end

    // SCK runs from SETUP through HOLD; HOLD only waits out a half-period with SCK low
    assign clk_en_c = (state_q != ST_IDLE);
    assign sck_en_c = (state_q != ST_HOLD);

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clock       (clock),
        .reset       (reset),
        .en_i        (clk_en_c),
        .sck_en_i    (sck_en_c),
        .sclk_o      (sclk_w),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

`ifdef SPI_MASTER_PARITY_EN
    logic err_q;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Transaction FSM with shift registers; mosi changes on falling SCK, miso sampled on rising
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
`ifdef SPI_MASTER_PARITY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // done_q blocks a start landing in the completion cycle
                    if (bus.start && !done_q && (bus.slave_sel <= 2'(SPI_SLV_BAS))) begin
                        tx_sr_q   <= frame_c[SPI_TX_FRAME-2:0];
                        mosi_q    <= frame_c[SPI_TX_FRAME-1];
                        cs_n_q    <= spi_cs_decode(bus.slave_sel);
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (rise_tick_c) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (fall_tick_c) begin
                        if (bit_cnt_q == SPI_CNT_W'(SPI_TX_FRAME - 1)) begin
                            mosi_q    <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= ST_RX;
                        end else begin
                            mosi_q    <= tx_sr_q[SPI_TX_FRAME-2];
                            tx_sr_q   <= {tx_sr_q[SPI_TX_FRAME-3:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
                        end
                    end
                end
                ST_RX: begin
                    if (rise_tick_c) begin
                        rx_sr_q   <= {rx_sr_q[SPI_RX_FRAME-2:0], bus.miso};
                        bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
                    end else if (fall_tick_c && (bit_cnt_q == SPI_CNT_W'(SPI_RX_FRAME))) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rise_tick_c) begin
                        cs_n_q   <= '1;
                        result_q <= rx_sr_q[SPI_RX_FRAME-1 -: SPI_RX_BITS];
`ifdef SPI_MASTER_PARITY_EN
                        err_q    <= ^rx_sr_q;
`endif
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.sclk   = sclk_w;
    assign bus.mosi   = mosi_q;
    assign bus.cs_n   = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vectors against spi_master with a mode-0 slave model.
// With SPI_MASTER_PARITY_EN defined the bench runs at CLK_DIV=1 and checks parity.
module tb_spi_master;

`ifdef SPI_MASTER_PARITY_EN
    localparam int unsigned D  = 1;
    localparam int unsigned PB = 1;
`else
    localparam int unsigned D  = 2;
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned TXB = 68 + PB;
    localparam int unsigned RXB = 32 + PB;
    localparam int unsigned LAT = D * (201 + 4 * PB);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_if bus();

    spi_master #(.CLK_DIV(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] resp;
        logic        par_ok;
        logic [2:0]  exp_cs;
        logic [31:0] exp_res;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned rise_cnt = 0;
    int unsigned done_cnt = 0;
    logic [127:0] mosi_cap = '0;
    logic [32:0]  slv_word = '0;

    // Slave model: capture MOSI on rising SCK, shift response out on falling SCK
    always @(posedge bus.sclk) begin
        mosi_cap = {mosi_cap[126:0], bus.mosi};
        rise_cnt++;
    end

    always @(negedge bus.sclk) begin
        if (rise_cnt >= TXB && rise_cnt < TXB + RXB)
            bus.miso = slv_word[RXB - 1 - (rise_cnt - TXB)];
        else
            bus.miso = 1'b0;
    end

    always @(posedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; entered and left on a negedge
    task automatic run_txn(input vec_t v, input int restart_at, input bit start_on_done);
        logic [67:0] f;
        logic [68:0] f69;
        logic        exp_err;
        int          c;
        int unsigned d0;
        f        = {v.op, v.a, v.b};
        f69      = (PB == 1) ? {f, ^f} : {1'b0, f};
        exp_err  = (PB == 1) && !v.par_ok;
        slv_word = (PB == 1) ? {v.resp, (^v.resp) ^ !v.par_ok} : {1'b0, v.resp};
        rise_cnt = 0;
        mosi_cap = '0;
        d0       = done_cnt;

        bus.start = 1'b1;
        bus.slave_sel = v.sel;
        bus.opcode = v.op;
        bus.operand_a = v.a;
        bus.operand_b = v.b;
        @(negedge clock);
        bus.start = 1'b0;
        chk("cs_n_accept", 128'(bus.cs_n), 128'(v.exp_cs));
        chk("busy_accept", 128'(bus.busy), 128'(1));
        chk("mosi_first",  128'(bus.mosi), 128'(v.op[3]));

        c = 0;
        while (bus.done !== 1'b1 && c < int'(LAT) + 40) begin
            if (c == int'(LAT) - 1) begin
                chk("cs_n_hold", 128'(bus.cs_n), 128'(v.exp_cs));
                chk("busy_hold", 128'(bus.busy), 128'(1));
                chk("sclk_hold", 128'(bus.sclk), 128'(0));
            end
            if (c == restart_at) begin
                bus.start = 1'b1;
                bus.opcode = ~v.op;
                bus.operand_a = ~v.a;
                bus.operand_b = ~v.b;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
            c++;
        end
        bus.start = 1'b0;

        chk("done_latency", 128'(c), 128'(LAT));
        chk("result",       128'(bus.result), 128'(v.exp_res));
        chk("err",          128'(bus.err), 128'(exp_err));
        chk("busy_at_done", 128'(bus.busy), 128'(0));
        chk("cs_n_release", 128'(bus.cs_n), 128'(3'b111));
        chk("sclk_edges",   128'(rise_cnt), 128'(TXB + RXB));
        chk("mosi_frame",   128'(mosi_cap[RXB +: 69]), 128'(f69));
        chk("mosi_rx_zero", 128'(mosi_cap[RXB-1:0]), 128'(0));

        if (start_on_done) begin
            bus.start = 1'b1;
            bus.slave_sel = v.sel;
        end
        @(negedge clock);
        bus.start = 1'b0;
        chk("done_pulse",  128'(bus.done), 128'(0));
        chk("done_count",  128'(done_cnt - d0), 128'(1));
        chk("result_held", 128'(bus.result), 128'(v.exp_res));
        chk("busy_after",  128'(bus.busy), 128'(0));
    endtask

    initial begin
        int unsigned d0;
        bus.start = 1'b0;
        bus.slave_sel = '0;
        bus.opcode = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.miso = 1'b0;

        //         sel    op     a              b              resp           ok    cs      res
        vecs[0] = '{2'd0, 4'h0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b1, 3'b110, 32'h0000_0007};
        vecs[1] = '{2'd1, 4'h2, 32'h1234_5678, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 3'b101, 32'hDEAD_BEEF};
        vecs[2] = '{2'd2, 4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0001, 1'b1, 3'b011, 32'h8000_0001};
        vecs[3] = '{2'd0, 4'hF, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h0000_0001, 1'b0, 3'b110, 32'h0000_0001};
        vecs[4] = '{2'd0, 4'h1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b1, 3'b110, 32'h0000_0001};
        vecs[5] = '{2'd1, 4'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b101, 32'h0000_0000};

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_busy",   128'(bus.busy), 128'(0));
        chk("rst_done",   128'(bus.done), 128'(0));
        chk("rst_result", 128'(bus.result), 128'(0));
        chk("rst_err",    128'(bus.err), 128'(0));
        chk("rst_sclk",   128'(bus.sclk), 128'(0));
        chk("rst_mosi",   128'(bus.mosi), 128'(0));
        chk("rst_cs_n",   128'(bus.cs_n), 128'(3'b111));
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NV; i++) run_txn(vecs[i], -1, 1'b0);

        // Second start mid-transfer with different operands is ignored
        run_txn(vecs[1], 50, 1'b0);

        // Start in the done cycle is ignored
        run_txn(vecs[2], -1, 1'b1);

        // Invalid slave index
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.slave_sel = 2'd3;
        @(negedge clock);
        bus.start = 1'b0;
        chk("inv_cs_n", 128'(bus.cs_n), 128'(3'b111));
        chk("inv_busy", 128'(bus.busy), 128'(0));
        repeat (30) @(negedge clock);
        chk("inv_cs_n_late", 128'(bus.cs_n), 128'(3'b111));
        chk("inv_sclk",      128'(bus.sclk), 128'(0));
        chk("inv_no_done",   128'(done_cnt - d0), 128'(0));

        // Reset in the middle of a transfer
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.slave_sel = 2'd1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (119) @(negedge clock);
        chk("mid_busy", 128'(bus.busy), 128'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_sclk",   128'(bus.sclk), 128'(0));
        chk("mid_rst_cs_n",   128'(bus.cs_n), 128'(3'b111));
        chk("mid_rst_busy",   128'(bus.busy), 128'(0));
        chk("mid_rst_mosi",   128'(bus.mosi), 128'(0));
        chk("mid_rst_result", 128'(bus.result), 128'(0));
        @(negedge clock);
        reset = 1'b1;
        repeat (int'(LAT) + 20) @(negedge clock);
        chk("mid_no_done", 128'(done_cnt - d0), 128'(0));
        chk("mid_idle",    128'(bus.busy), 128'(0));

        run_txn(vecs[0], -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
